iterative_multiplier: RTL
=========================

# iterative_multiplier

Sequential shift-and-add unsigned multiplier, the inverse companion to the iterative divider. It uses the same enable-loaded register datapath and computes one partial product per clock. A single-cycle `start` loads the operands. A one-cycle `done` pulse marks a valid product, which is then held on `P`. It sits beside the divider behind the same operand registers.

## Interface
- `WIDTH`, default 4: operand width in bits. Legal range is 2–16.
- `clk`  input  1: the single clock; all state changes on the rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `start`  input  1: request a multiply. Sampled only in IDLE.
- `A`  input  WIDTH: multiplicand, unsigned. Sampled on the accepting edge.
- `B`  input  WIDTH: multiplier, unsigned. Sampled on the accepting edge.
- `busy`  output  1: high whenever the state is not IDLE.
- `done`  output  1: one-cycle pulse when `P` is updated.
- `P`  output  2*WIDTH: product register, held until the next completion.

## Operation
- Internal registers:
  - `mcand`: 2*WIDTH bits, multiplicand shifted left.
  - `mplier`: WIDTH bits, multiplier shifted right.
  - `acc`: 2*WIDTH bits.
  - `cnt`: clog2(WIDTH) bits.
  - `state`.
- States: IDLE, CALC, DONE.
- IDLE with `start`=1: load `mcand`={0,A}, `mplier`=B, `acc`=0, `cnt`=0, and go to CALC.
  - `start` is ignored in CALC and DONE.
  - No queuing; a `start` held high across DONE is accepted again in the next IDLE cycle.
- Each CALC edge performs one iteration:
  - If `mplier[0]`=1, then `acc` ← `acc`+`mcand`. The sum is 2*WIDTH bits and cannot overflow.
  - `mcand` ← `mcand`<<1.
  - `mplier` ← `mplier`>>1.
  - `cnt` ← `cnt`+1.
- Exit from CALC: when the current iteration has `cnt`==WIDTH-1, go to DONE on that edge and load `P` ← the post-add `acc` value.
- DONE: `done`=1 for exactly this one cycle. Next edge goes to IDLE unconditionally.
- `P` changes only on the CALC→DONE edge and on reset.
- Operand inputs may change freely after the accepting edge; they do not affect the computation in flight.

## Timing
- Reset values:
  - `state`=IDLE.
  - `busy`=0, `done`=0, `P`=0.
  - `mcand`, `mplier`, `acc` and `cnt` all 0.
- Edge k0 accepts `start`. Iterations occur on edges k0+1 … k0+WIDTH.
- `done` and the new `P` are visible after edge k0+WIDTH, for one cycle. `busy` falls after edge k0+WIDTH+1.
- Throughput: one result per WIDTH+2 cycles when `start` is held high.
- `busy` rises after edge k0. It is registered-state derived and glitch-free.
- Reset mid-operation aborts immediately, without waiting for a clock edge:
  - State returns to IDLE and `P` clears to 0.
  - No `done` pulse is produced.
  - The first edge after reset release may accept `start`.
- Extreme operands `A`=2^WIDTH−1 and `B`=2^WIDTH−1 must produce `P`=(2^WIDTH−1)^2 exactly.

## Configuration
- `MULT_EARLY_EXIT_EN`, when defined: CALC also exits to DONE on any edge where the post-shift `mplier` is 0.
  - Latency becomes (index of B's highest set bit + 1) iterations, with a minimum of 1.
  - With `B`=0, CALC lasts 1 iteration and `P`=0.
  - The result is identical to the full run; only the cycle count changes.
- When undefined: always exactly WIDTH iterations, regardless of operand values.

## Test plan
All cases use `WIDTH`=4.

1. Reset held 3 cycles, then released → `P`=8'h00, `done`=0, `busy`=0. Then `start` with `A`=13, `B`=11 → `done` pulses 4 cycles after accept with `P`=8'h8F (143); `busy` is high for 5 cycles.
2. Extreme case: `A`=15, `B`=15 → `P`=8'hE1 (225). Then `A`=0, `B`=9 → `P`=8'h00, with `done` at the same latency as case 1.
3. Accept `A`=3, `B`=5. Pulse `start` again 2 cycles later with `A`=7, `B`=7 → the second `start` is ignored, `P`=8'h0F, and only one `done` occurs.
4. Accept `A`=9, `B`=6. Assert `reset` asynchronously between edges at iteration 2 → `busy` and `P` go to 0 immediately and no `done` follows. After release, `A`=2, `B`=3 → `P`=8'h06.
5. Hold `start`=1 continuously with `A`=5, `B`=4 → `done` repeats every 6 cycles and `P` stays 8'h14.
6. With `MULT_EARLY_EXIT_EN` defined: `A`=10, `B`=1 → `done` 1 cycle after accept with `P`=8'h0A. Then `B`=4'b0100 → 3 iterations, `P`=8'h28. Then `B`=0 → 1 iteration, `P`=0.

Source files
------------

// File: rtl/iterative_multiplier.sv
// Shift-and-add unsigned multiplier: one partial product per clock, done pulse on completion.
// Optional MULT_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module iterative_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   P
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;

  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_shift;
  logic                 last_iter;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
    end
  end

  // The accumulator holds at most (2^W-1)^2, so the 2W-bit add never overflows.
  assign acc_sum      = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_shift = mplier_q >> 1;

`ifdef MULT_EARLY_EXIT_EN
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_shift == '0);
`else
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`endif

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (last_iter) begin
          p_d     = acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign P    = p_q;

endmodule
